// File: rtl/pongfpga_pkg.sv
// Shared definitions for the Pong switch poller: PIO register map and poll FSM states.
package pongfpga_pkg;

    localparam logic [1:0] PIO_DATA    = 2'd0;
    localparam logic [1:0] PIO_IRQMASK = 2'd2;
    localparam logic [1:0] PIO_EDGE    = 2'd3;

    typedef enum logic [2:0] {
        INIT     = 3'd0,
        IDLE     = 3'd1,
        RD_EC    = 3'd2,
        EC_WAIT  = 3'd3,
        CLR      = 3'd4,
        RD_DAT   = 3'd5,
        DAT_WAIT = 3'd6
    } poll_state_t;

endpackage

// File: rtl/pongfpga_tick_div.sv
// Poll interval down-counter: counts to zero and holds there until reloaded.
module pongfpga_tick_div #(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic reload,
    output logic zero
);

    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] count;

    // Reload starts a fresh interval; otherwise count down and park at zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= LOAD;
        end else if (reload) begin
            count <= LOAD;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pongfpga_sw_poller.sv
// Hardware Avalon-MM initiator that services the switch PIO: writes the IRQ mask
// once after reset, then periodically reads/clears edge_capture and reads levels.
// Bus outputs are registered and loaded on the edge that enters each access
// state, so the bus activity of a state is visible during that state's cycle.
module pongfpga_sw_poller
    import pongfpga_pkg::*;
#(
    parameter int          WIDTH         = 3,
    parameter int          POLL_DIV      = 50000,
    parameter logic [31:0] IRQ_MASK_INIT = 32'd0
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic [1:0]       avm_address,
    output logic             avm_chipselect,
    output logic             avm_write_n,
    output logic [31:0]      avm_writedata,
    input  logic [31:0]      avm_readdata,
    input  logic             enable,
    output logic [WIDTH-1:0] sw_state,
    output logic             sw_valid,
    output logic [WIDTH-1:0] edge_event,
    output logic             busy
);

    poll_state_t      state;
    logic [WIDTH-1:0] ec;
    logic [WIDTH-1:0] rd_bits;
    logic             tick_zero;
    logic             start;

    // Only the low WIDTH bits of the PIO word carry switch information.
    assign rd_bits = avm_readdata[WIDTH-1:0];

    if (WIDTH < 32) begin : g_unused_hi
        logic unused_readdata_hi;
        assign unused_readdata_hi = ^avm_readdata[31:WIDTH];
    end

    // A poll may only begin from IDLE once the interval has elapsed and polling is enabled.
    assign start = (state == IDLE) && tick_zero && enable;

    pongfpga_tick_div #(
        .DIV (POLL_DIV)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .reload  (start),
        .zero    (tick_zero)
    );

    // Poll sequencer and registered bus driver.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= INIT;
            avm_address    <= '0;
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            avm_writedata  <= '0;
            sw_state       <= '0;
            sw_valid       <= 1'b0;
            edge_event     <= '0;
            busy           <= 1'b1;
            ec             <= '0;
        end else begin
            edge_event <= '0;
            case (state)
                INIT: begin
                    // Single mask write; busy stays high while it is on the bus.
                    avm_chipselect <= 1'b1;
                    avm_write_n    <= 1'b0;
                    avm_address    <= PIO_IRQMASK;
                    avm_writedata  <= IRQ_MASK_INIT;
                    state          <= IDLE;
                end
                IDLE: begin
                    avm_write_n <= 1'b1;
                    if (start) begin
                        avm_chipselect <= 1'b1;
                        avm_address    <= PIO_EDGE;
                        busy           <= 1'b1;
                        state          <= RD_EC;
                    end else begin
                        avm_chipselect <= 1'b0;
                        busy           <= 1'b0;
                    end
                end
                RD_EC: begin
                    avm_chipselect <= 1'b0;
                    state          <= EC_WAIT;
                end
                EC_WAIT: begin
                    // Clear edge_capture only when something was captured.
                    ec             <= rd_bits;
                    avm_chipselect <= 1'b1;
                    if (rd_bits != '0) begin
                        avm_write_n   <= 1'b0;
                        avm_address   <= PIO_EDGE;
                        avm_writedata <= '0;
                        state         <= CLR;
                    end else begin
                        avm_address <= PIO_DATA;
                        state       <= RD_DAT;
                    end
                end
                CLR: begin
                    avm_write_n <= 1'b1;
                    avm_address <= PIO_DATA;
                    state       <= RD_DAT;
                end
                RD_DAT: begin
                    avm_chipselect <= 1'b0;
                    state          <= DAT_WAIT;
                end
                DAT_WAIT: begin
                    sw_state   <= rd_bits;
                    sw_valid   <= 1'b1;
                    edge_event <= ec;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    avm_chipselect <= 1'b0;
                    avm_write_n    <= 1'b1;
                    state          <= INIT;
                end
            endcase
        end
    end

endmodule
